// File: rtl/fft_seq_pkg.sv
// fft_seq_pkg: state encoding and default sizing shared by the FFT frame sequencer
package fft_seq_pkg;
  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;
  localparam int FFT_LEN_DEF = 256;
  localparam int DATA_W_DEF = 16;
  localparam int LOG2_LEN = $clog2(FFT_LEN_DEF);
  localparam int MAG_W = DATA_W_DEF + 1;
endpackage

// File: rtl/fft_mag_tracker.sv
// fft_mag_tracker: |re|+|im| per bin, keeps the strictly largest magnitude in bins 1..N/2-1
module fft_mag_tracker
  import fft_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int BIN_W = LOG2_LEN,
  parameter int MW = MAG_W
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [DATA_W-1:0] re,
  input  logic [DATA_W-1:0] im,
  input  logic [BIN_W-1:0]  bin,
  input  logic              valid,
  input  logic              clear,
  output logic [MW-1:0]     peak,
  output logic [BIN_W-1:0]  peak_idx
);
  logic [DATA_W-1:0] w_abs_re, w_abs_im;
  logic [MW-1:0] w_mag, r_peak;
  logic [BIN_W-1:0] r_idx;
  logic w_upd;
  always_comb begin
    w_abs_re = re[DATA_W-1] ? ~re + 1'b1 : re;
    w_abs_im = im[DATA_W-1] ? ~im + 1'b1 : im;
    w_mag = MW'({1'b0, w_abs_re}) + MW'({1'b0, w_abs_im});
    w_upd = valid && |bin && !bin[BIN_W-1] && w_mag > r_peak;
    peak = r_peak;
    peak_idx = r_idx;
  end
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      r_peak <= '0;
      r_idx <= '0;
    end else if (clear) begin
      r_peak <= '0;
      r_idx <= '0;
    end else if (w_upd) begin
      r_peak <= w_mag;
      r_idx <= bin;
    end
endmodule

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: streams one frame of samples into an FFT core, then reports the
// strongest positive-frequency bin of the returned spectrum
module fft_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int FFT_LEN = FFT_LEN_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              enable,
  input  logic              smp_valid,
  input  logic [DATA_W-1:0] smp_data,
  output logic              sink_valid,
  input  logic              sink_ready,
  output logic              sink_sop,
  output logic              sink_eop,
  output logic [DATA_W-1:0] sink_real,
  output logic [DATA_W-1:0] sink_imag,
  output logic [1:0]        sink_error,
  output logic              inverse,
  input  logic              source_valid,
  output logic              source_ready,
  input  logic              source_sop,
  input  logic              source_eop,
  input  logic [1:0]        source_error,
  input  logic [DATA_W-1:0] source_real,
  input  logic [DATA_W-1:0] source_imag,
  output logic [7:0]        max_index_byte,
  output logic              index_valid,
  output logic              frame_err,
  output logic [7:0]        overrun_cnt,
  output logic              busy
);
  localparam int BIN_W = $clog2(FFT_LEN);
  state_t r_state, w_next;
  logic r_full, r_err_seen, r_frame_err;
  logic [DATA_W-1:0] r_hold;
  logic [BIN_W-1:0] r_cnt, w_bin, w_peak_idx;
  logic [7:0] r_ovr, r_max;
  logic [DATA_W:0] w_peak;
  logic w_start, w_hs, w_last, w_acc, w_drop, w_beat, w_load;
  always_comb begin
    sink_valid = r_state == FILL && r_full;
    w_start = r_state == IDLE && enable;
    w_hs = sink_valid && sink_ready;
    w_last = w_hs && r_cnt == BIN_W'(FFT_LEN - 1);
    w_acc = r_state == FILL && smp_valid && (!r_full || w_hs);
    w_drop = r_state == FILL && smp_valid && r_full && !w_hs;
    w_beat = r_state == DRAIN && source_valid;
    w_bin = source_sop ? '0 : r_cnt + 1'b1;
    w_load = r_state == DONE && !r_err_seen;
    w_next = w_start ? FILL :
             (r_state == FILL && w_last) ? DRAIN :
             (w_beat && source_eop) ? DONE :
             r_state == DONE ? IDLE : r_state;
    sink_sop = sink_valid && r_cnt == '0;
    sink_eop = sink_valid && r_cnt == BIN_W'(FFT_LEN - 1);
    sink_real = r_hold;
    sink_imag = '0;
    sink_error = '0;
    inverse = 1'b0;
    source_ready = r_state == DRAIN;
    index_valid = w_load;
    max_index_byte = w_load ? (|w_peak ? 8'(w_peak_idx) : 8'd0) : r_max;
    frame_err = r_frame_err || (r_state == DONE && r_err_seen);
    overrun_cnt = r_ovr;
    busy = r_state != IDLE;
  end
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      r_full <= 1'b0;
      r_hold <= '0;
      r_cnt <= '0;
      r_ovr <= '0;
      r_max <= '0;
      r_err_seen <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_start) begin
        r_full <= 1'b0;
        r_cnt <= '0;
        r_err_seen <= 1'b0;
      end else begin
        if (w_acc) begin
          r_full <= 1'b1;
          r_hold <= smp_data;
        end else if (w_hs) r_full <= 1'b0;
        if (w_hs) r_cnt <= r_cnt + 1'b1;
        else if (w_beat) r_cnt <= w_bin;
        if (w_beat && |source_error) r_err_seen <= 1'b1;
      end
      if (w_drop && r_ovr != 8'hFF) r_ovr <= r_ovr + 1'b1;
      r_frame_err <= frame_err;
      r_max <= max_index_byte;
    end
  fft_mag_tracker #(.DATA_W(DATA_W), .BIN_W(BIN_W), .MW(DATA_W + 1)) u_trk (
    .clk_clk(clk_clk),
    .reset_reset_n(reset_reset_n),
    .re(source_real),
    .im(source_imag),
    .bin(w_bin),
    .valid(w_beat),
    .clear(w_start),
    .peak(w_peak),
    .peak_idx(w_peak_idx)
  );
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: random sample/spectrum traffic against a frame-level peak model
module tb_fft_frame_sequencer;
  localparam int FFT_LEN = 256;
  localparam int DATA_W = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  logic enable = 1'b0, smp_valid = 1'b0, sink_ready = 1'b0;
  logic source_valid = 1'b0, source_sop = 1'b0, source_eop = 1'b0;
  logic [DATA_W-1:0] smp_data = '0, source_real = '0, source_imag = '0;
  logic [1:0] source_error = '0;
  logic sink_valid, sink_sop, sink_eop, inverse, source_ready, index_valid, frame_err, busy;
  logic [DATA_W-1:0] sink_real, sink_imag;
  logic [1:0] sink_error;
  logic [7:0] max_index_byte, overrun_cnt;

  logic [DATA_W-1:0] sp_re [FFT_LEN];
  logic [DATA_W-1:0] sp_im [FFT_LEN];
  logic [1:0] sp_err [FFT_LEN];
  int n_tests = 0, n_fail = 0, m_ovr = 0, exp_iv = 0, iv_seen = 0;
  logic [7:0] m_max = '0;
  logic m_ferr = 1'b0;

  always #5 clk = ~clk;
  always @(negedge clk) if (index_valid === 1'b1) iv_seen++;

  fft_frame_sequencer #(.FFT_LEN(FFT_LEN), .DATA_W(DATA_W)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .enable(enable),
    .smp_valid(smp_valid), .smp_data(smp_data),
    .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_real(sink_real), .sink_imag(sink_imag), .sink_error(sink_error), .inverse(inverse),
    .source_valid(source_valid), .source_ready(source_ready), .source_sop(source_sop),
    .source_eop(source_eop), .source_error(source_error),
    .source_real(source_real), .source_imag(source_imag),
    .max_index_byte(max_index_byte), .index_valid(index_valid), .frame_err(frame_err),
    .overrun_cnt(overrun_cnt), .busy(busy)
  );

  function automatic logic [57:0] all_outs();
    return {busy, sink_valid, sink_sop, sink_eop, source_ready, index_valid, frame_err, inverse,
            overrun_cnt, max_index_byte, sink_real, sink_imag, sink_error};
  endfunction

  function automatic int ref_peak();
    int best = 0, bm = 0;
    for (int b = 1; b < FFT_LEN / 2; b++) begin
      int a = int'($signed(sp_re[b]));
      int c = int'($signed(sp_im[b]));
      int m = (a < 0 ? -a : a) + (c < 0 ? -c : c);
      if (m > bm) begin
        bm = m;
        best = b;
      end
    end
    return best;
  endfunction

  task automatic set_flat(input int re, input int im);
    for (int b = 0; b < FFT_LEN; b++) begin
      sp_re[b] = 16'(re);
      sp_im[b] = 16'(im);
      sp_err[b] = 2'b00;
    end
  endtask

  task automatic run_frame(input bit en_after, input bit stall, input int stop_at,
                           input int p_rdy, input int p_sv);
    int hs = 0, cyc = 0, errs = 0, beat = 0, base = m_ovr;
    bit m_full = 0, rdy, sv, vld, err_any = 0;
    logic [DATA_W-1:0] m_data = '0, d;
    enable = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL fill_entry: busy=%b required 1", busy); end
    enable = en_after;
    while (hs < stop_at && cyc < 20000) begin
      if (sink_valid !== m_full || sink_sop !== (m_full && hs == 0) ||
          sink_eop !== (m_full && hs == FFT_LEN - 1) || (m_full && sink_real !== m_data) ||
          source_ready !== 1'b0 || {sink_imag, sink_error, inverse} !== '0) errs++;
      rdy = (stall && cyc < 10) ? 1'b0 : ($urandom_range(99) < p_rdy);
      sv = (stall && cyc < 10) ? 1'b1 : ($urandom_range(99) < p_sv);
      if (m_full && rdy && hs == FFT_LEN - 1) sv = 1'b0;
      d = 16'($urandom);
      sink_ready = rdy;
      smp_valid = sv;
      smp_data = d;
      if (sv && m_full && !rdy) m_ovr = m_ovr < 255 ? m_ovr + 1 : 255;
      else begin
        if (m_full && rdy) begin hs++; m_full = 0; end
        if (sv) begin m_full = 1; m_data = d; end
      end
      @(posedge clk); #1;
      cyc++;
      if (stall && cyc == 10) begin
        n_tests++;
        if (overrun_cnt !== 8'(base + 9)) begin
          n_fail++;
          $display("FAIL stall_overrun: overrun_cnt=%0d required %0d", overrun_cnt, base + 9);
        end
      end
    end
    smp_valid = 1'b0;
    sink_ready = 1'b0;
    n_tests++;
    if (errs != 0 || hs != stop_at) begin
      n_fail++;
      $display("FAIL fill_protocol: %0d bad cycles, %0d handshakes, required 0 and %0d", errs, hs, stop_at);
    end
    if (stop_at < FFT_LEN) return;
    n_tests++;
    if (overrun_cnt !== 8'(m_ovr) || source_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_entry: overrun_cnt=%0d source_ready=%b required %0d and 1", overrun_cnt, source_ready, m_ovr);
    end
    errs = 0;
    while (beat < FFT_LEN && cyc < 20000) begin
      if (source_ready !== 1'b1 || index_valid !== 1'b0 || sink_valid !== 1'b0) errs++;
      vld = $urandom_range(99) < 70;
      source_valid = vld;
      source_sop = vld && beat == 0;
      source_eop = vld && beat == FFT_LEN - 1;
      source_real = vld ? sp_re[beat] : 16'($urandom);
      source_imag = vld ? sp_im[beat] : 16'($urandom);
      source_error = vld ? sp_err[beat] : 2'($urandom);
      smp_valid = 1'($urandom);
      smp_data = 16'($urandom);
      if (vld) begin
        err_any |= sp_err[beat] != 2'b00;
        beat++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    {source_valid, source_sop, source_eop, smp_valid} = '0;
    source_error = '0;
    if (!err_any) begin
      m_max = 8'(ref_peak());
      exp_iv++;
    end
    m_ferr |= err_any;
    n_tests++;
    if (errs != 0 || beat != FFT_LEN) begin
      n_fail++;
      $display("FAIL drain_protocol: %0d bad cycles, %0d beats, required 0 and %0d", errs, beat, FFT_LEN);
    end
    n_tests++;
    if (index_valid !== !err_any || max_index_byte !== m_max || frame_err !== m_ferr) begin
      n_fail++;
      $display("FAIL done_result: iv=%b idx=%0d ferr=%b required %b %0d %b",
               index_valid, max_index_byte, frame_err, !err_any, m_max, m_ferr);
    end
    n_tests++;
    if (overrun_cnt !== 8'(m_ovr)) begin
      n_fail++;
      $display("FAIL drain_overrun: overrun_cnt=%0d required %0d", overrun_cnt, m_ovr);
    end
    @(posedge clk); #1;
    n_tests++;
    if (index_valid !== 1'b0 || busy !== 1'b0 || max_index_byte !== m_max || frame_err !== m_ferr) begin
      n_fail++;
      $display("FAIL after_done: iv=%b busy=%b idx=%0d ferr=%b required 0 0 %0d %b",
               index_valid, busy, max_index_byte, frame_err, m_max, m_ferr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (all_outs() !== '0) begin n_fail++; $display("FAIL reset_outputs: %h required 0", all_outs()); end
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_enable: busy=%b required 0", busy); end
  endtask

  task automatic test_peak_basic();
    set_flat(10, 10);
    sp_re[37] = 16'(1000);
    sp_im[37] = 16'(-200);
    run_frame(1, 0, FFT_LEN, 100, 80);
  endtask

  task automatic test_tie();
    set_flat(1, 2);
    sp_re[20] = 16'(300);
    sp_im[20] = 16'(-200);
    sp_re[90] = 16'(-500);
    sp_im[90] = 16'(0);
    run_frame(1, 0, FFT_LEN, 100, 90);
  endtask

  task automatic test_upper_half();
    set_flat(0, 0);
    sp_re[200] = 16'(30000);
    sp_re[5] = 16'(100);
    run_frame(1, 0, FFT_LEN, 100, 70);
  endtask

  task automatic test_abs_boundary();
    set_flat(0, 0);
    sp_re[0] = 16'(32767);
    sp_im[0] = 16'(32767);
    sp_re[49] = 16'(32767);
    sp_im[49] = 16'(32767);
    sp_re[50] = 16'h8000;
    sp_im[50] = 16'h8000;
    run_frame(1, 0, FFT_LEN, 100, 100);
    set_flat(0, 0);
    run_frame(0, 0, FFT_LEN, 100, 100);
  endtask

  task automatic test_overrun();
    set_flat(3, -4);
    sp_im[64] = 16'(-900);
    run_frame(0, 1, FFT_LEN, 80, 90);
  endtask

  task automatic test_enable_drop();
    set_flat(-7, 7);
    sp_re[127] = 16'(50);
    run_frame(0, 0, FFT_LEN, 60, 80);
    repeat (5) @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL enable_drop_idle: busy=%b required 0", busy); end
  endtask

  task automatic test_error();
    set_flat(10, 0);
    sp_re[60] = 16'(4000);
    sp_err[3] = 2'b01;
    run_frame(1, 0, FFT_LEN, 90, 90);
    sp_err[3] = 2'b00;
    sp_re[61] = 16'(5000);
    run_frame(0, 0, FFT_LEN, 90, 90);
  endtask

  task automatic test_reset_midframe();
    set_flat(2, 2);
    sp_re[11] = 16'(-77);
    run_frame(1, 0, 100, 70, 90);
    rst_n = 1'b0;
    #2;
    n_tests++;
    if (all_outs() !== '0) begin n_fail++; $display("FAIL async_reset_outputs: %h required 0", all_outs()); end
    m_ovr = 0;
    m_max = '0;
    m_ferr = 1'b0;
    enable = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    n_tests++;
    if (iv_seen !== exp_iv || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_discard: iv_count=%0d busy=%b required %0d 0", iv_seen, busy, exp_iv);
    end
    run_frame(1, 0, FFT_LEN, 75, 85);
    run_frame(0, 0, FFT_LEN, 100, 60);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 6; f++) begin
      for (int b = 0; b < FFT_LEN; b++) begin
        sp_re[b] = $urandom_range(3) == 0 ? 16'($urandom) : 16'($urandom_range(400)) - 16'd200;
        sp_im[b] = $urandom_range(3) == 0 ? 16'($urandom) : 16'($urandom_range(400)) - 16'd200;
        sp_err[b] = 2'b00;
      end
      if (f == 2) sp_err[$urandom_range(FFT_LEN - 1)] = 2'($urandom_range(1, 3));
      run_frame(f < 5, 0, FFT_LEN, f == 4 ? 15 : $urandom_range(40, 100), $urandom_range(50, 100));
      if (f == 4) begin
        n_tests++;
        if (overrun_cnt !== 8'hFF) begin n_fail++; $display("FAIL overrun_saturate: %0d required 255", overrun_cnt); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_peak_basic();
    test_tie();
    test_upper_half();
    test_abs_boundary();
    test_overrun();
    test_enable_drop();
    test_error();
    test_reset_midframe();
    test_back_to_back();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (iv_seen !== exp_iv) begin n_fail++; $display("FAIL index_valid_count: %0d required %0d", iv_seen, exp_iv); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
